// File: rtl/fft_peak_detector.sv
// Per-frame peak search over the positive-frequency half of an FFT magnitude stream.
// Holds the strongest bin and its magnitude until software acknowledges the result.
module fft_peak_detector #(
  parameter int FFT_SIZE = 1024,
  parameter int MAG_W    = 21,
  parameter int MIN_BIN  = 1,
  parameter int BIN_W    = $clog2(FFT_SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_ce,
  input  logic             i_sync,
  input  logic [MAG_W-1:0] i_mag,
  input  logic [MAG_W-1:0] i_threshold,
  input  logic             i_ack,
  output logic             o_valid,
  output logic             o_detect,
  output logic [BIN_W-1:0] o_peak_bin,
  output logic [MAG_W-1:0] o_peak_mag,
  output logic             o_overrun,
  output logic             o_resync
);

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    SCAN      = 2'd1,
    COMMIT    = 2'd2
  } state_t;

  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(FFT_SIZE / 2 - 1);
  localparam logic [BIN_W-1:0] MIN_IDX  = BIN_W'(MIN_BIN);
  localparam logic [BIN_W-1:0] BIN_ONE  = BIN_W'(1);
  localparam logic [BIN_W-1:0] BIN_ZERO = {BIN_W{1'b0}};
  localparam logic [MAG_W-1:0] MAG_ZERO = {MAG_W{1'b0}};

  state_t           state_q;
  logic [BIN_W-1:0] bin_cnt_q, bin_cnt_d;
  logic [BIN_W-1:0] run_bin_q, run_bin_d;
  logic [MAG_W-1:0] run_max_q, run_max_d;
  logic [BIN_W-1:0] peak_bin_q;
  logic [MAG_W-1:0] peak_mag_q;
  logic             valid_q, detect_q, overrun_q, resync_q;

  logic [BIN_W-1:0] bin_idx_s;
  logic             in_win_s, take_s, mid_sync_s, last_s;

  // Classify the presented sample; a sync sample is always bin 0 of a fresh search
  always_comb begin
    bin_idx_s  = i_sync ? BIN_ZERO : bin_cnt_q;
    bin_cnt_d  = bin_idx_s + BIN_ONE;
    in_win_s   = (bin_idx_s >= MIN_IDX) && (bin_idx_s <= LAST_BIN);
    take_s     = in_win_s && ((bin_idx_s == MIN_IDX) || (i_mag > run_max_q));
    mid_sync_s = i_sync && (bin_cnt_q != BIN_ZERO);
    last_s     = (bin_idx_s == LAST_BIN);
    run_max_d  = take_s ? i_mag     : (i_sync ? MAG_ZERO : run_max_q);
    run_bin_d  = take_s ? bin_idx_s : (i_sync ? BIN_ZERO : run_bin_q);
  end

  // Frame FSM, running maximum and held result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= WAIT_SYNC;
      bin_cnt_q  <= BIN_ZERO;
      run_bin_q  <= BIN_ZERO;
      run_max_q  <= MAG_ZERO;
      peak_bin_q <= BIN_ZERO;
      peak_mag_q <= MAG_ZERO;
      valid_q    <= 1'b0;
      detect_q   <= 1'b0;
      overrun_q  <= 1'b0;
      resync_q   <= 1'b0;
    end else begin
      if (i_ack) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
        resync_q  <= 1'b0;
      end
      // Commit overrides a same-cycle ack on o_valid; the run_* values are the completed frame
      if (state_q == COMMIT) begin
        peak_bin_q <= run_bin_q;
        peak_mag_q <= run_max_q;
        detect_q   <= (run_max_q >= i_threshold);
        valid_q    <= 1'b1;
        if (valid_q && !i_ack) begin
          overrun_q <= 1'b1;
        end
      end
      case (state_q)
        WAIT_SYNC: begin
          if (i_ce && i_sync) begin
            state_q   <= SCAN;
            bin_cnt_q <= bin_cnt_d;
            run_max_q <= run_max_d;
            run_bin_q <= run_bin_d;
          end
        end
        SCAN, COMMIT: begin
          if (i_ce) begin
            bin_cnt_q <= bin_cnt_d;
            run_max_q <= run_max_d;
            run_bin_q <= run_bin_d;
            state_q   <= last_s ? COMMIT : SCAN;
            if (mid_sync_s) begin
              resync_q <= 1'b1;
            end
          end else begin
            state_q <= SCAN;
          end
        end
        default: state_q <= WAIT_SYNC;
      endcase
    end
  end

  assign o_valid    = valid_q;
  assign o_detect   = detect_q;
  assign o_peak_bin = peak_bin_q;
  assign o_peak_mag = peak_mag_q;
  assign o_overrun  = overrun_q;
  assign o_resync   = resync_q;

endmodule

// File: tb/tb_fft_peak_detector.sv
// Scoreboard bench for fft_peak_detector at FFT_SIZE=16: expected peaks are queued when
// bin 7 of a synced frame is driven and compared when the commit shows up one clock later.
module tb_fft_peak_detector;

  localparam int N  = 16;
  localparam int MW = 21;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_ce, i_sync, i_ack;
  logic [MW-1:0] i_mag, i_threshold;
  logic          o_valid, o_detect, o_overrun, o_resync;
  logic [BW-1:0] o_peak_bin;
  logic [MW-1:0] o_peak_mag;

  fft_peak_detector #(.FFT_SIZE(N), .MAG_W(MW), .MIN_BIN(1)) dut (
    .clk(clk), .reset(reset), .i_ce(i_ce), .i_sync(i_sync), .i_mag(i_mag),
    .i_threshold(i_threshold), .i_ack(i_ack), .o_valid(o_valid), .o_detect(o_detect),
    .o_peak_bin(o_peak_bin), .o_peak_mag(o_peak_mag), .o_overrun(o_overrun),
    .o_resync(o_resync)
  );

  always #5 clk = ~clk;

  typedef struct {
    int bin;
    int mag;
    bit det;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   due = 0;
  bit   valid_m = 1'b0;
  bit   ov_m = 1'b0;
  bit   ack_commit_g = 1'b0;
  int   mags[N];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    check_eq("sb_depth", sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq("commit_valid", o_valid, valid_m);
      check_eq("commit_bin", o_peak_bin, e.bin);
      check_eq("commit_mag", o_peak_mag, e.mag);
      check_eq("commit_detect", o_detect, e.det);
      check_eq("commit_overrun", o_overrun, ov_m);
    end
  endtask

  // One clock: check a due commit, update the result model, then drive the inputs
  task automatic cycle(input bit ce, input bit sync, input int mag, input bit ack, input bit rst);
    bit a;
    @(negedge clk);
    a = ack;
    if (due > 0) begin
      due--;
      if (due == 0) pop_check();
    end
    if (rst) begin
      valid_m = 1'b0;
      ov_m    = 1'b0;
    end else if (due == 1) begin
      if (ack_commit_g) a = 1'b1;
      if (a) ov_m = 1'b0;
      if (valid_m && !a) ov_m = 1'b1;
      valid_m = 1'b1;
    end else if (a) begin
      valid_m = 1'b0;
      ov_m    = 1'b0;
    end
    i_ce   = ce;
    i_sync = sync;
    i_mag  = MW'(mag);
    i_ack  = a;
    reset  = rst;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic ack_pulse();
    cycle(1'b0, 1'b0, 0, 1'b1, 1'b0);
    idle(1);
  endtask

  function automatic exp_t model_peak();
    exp_t e;
    int best = 1;
    for (int b = 2; b < N / 2; b++) begin
      if (mags[b] > mags[best]) best = b;
    end
    e.bin = best;
    e.mag = mags[best];
    e.det = (mags[best] >= int'(i_threshold));
    return e;
  endfunction

  task automatic send_frame(input int nbins, input int gap, input bit with_sync);
    for (int b = 0; b < nbins; b++) begin
      for (int g = 0; g < gap; g++) cycle(1'b0, 1'b0, 0, 1'b0, 1'b0);
      cycle(1'b1, with_sync && (b == 0), mags[b], 1'b0, 1'b0);
      if (with_sync && b == N / 2 - 1) begin
        sb_q.push_back(model_peak());
        due = 2;
      end
    end
    idle(2);
  endtask

  task automatic set_mags(input int dc, input int base);
    for (int b = 0; b < N; b++) mags[b] = base;
    mags[0] = dc;
  endtask

  initial begin
    reset = 1'b1; i_ce = 1'b0; i_sync = 1'b0; i_ack = 1'b0;
    i_mag = '0; i_threshold = 21'd100;
    cycle(1'b0, 1'b0, 0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 0, 1'b0, 1'b1);
    idle(2);
    check_eq("rst_valid", o_valid, 1'b0);
    check_eq("rst_detect", o_detect, 1'b0);
    check_eq("rst_bin", o_peak_bin, 0);
    check_eq("rst_mag", o_peak_mag, 0);
    check_eq("rst_overrun", o_overrun, 1'b0);
    check_eq("rst_resync", o_resync, 1'b0);

    // DC dominates but is outside the window; threshold cleared
    set_mags(900, 10); mags[5] = 300;
    send_frame(N, 0, 1'b1);
    ack_pulse();
    check_eq("t1_ack_valid", o_valid, 1'b0);

    // Same frame, threshold above the peak
    i_threshold = 21'd400;
    send_frame(N, 0, 1'b1);
    ack_pulse();

    // Equal magnitudes keep the lower bin
    i_threshold = 21'd100;
    set_mags(900, 10); mags[2] = 50; mags[6] = 50;
    send_frame(N, 0, 1'b1);
    ack_pulse();

    // Two frames without ack
    set_mags(900, 10); mags[5] = 300;
    send_frame(N, 0, 1'b1);
    set_mags(0, 10); mags[3] = 500;
    send_frame(N, 0, 1'b1);
    check_eq("t3_overrun", o_overrun, 1'b1);
    ack_pulse();
    check_eq("t3_ack_valid", o_valid, 1'b0);
    check_eq("t3_ack_overrun", o_overrun, 1'b0);
    check_eq("t3_hold_bin", o_peak_bin, 3);

    // Sync arrives at bin 4: partial frame dropped, new frame counted from that sync
    set_mags(0, 10); mags[2] = 2000;
    send_frame(4, 0, 1'b1);
    check_eq("t4_partial_valid", o_valid, 1'b0);
    set_mags(0, 10); mags[6] = 700;
    send_frame(N, 0, 1'b1);
    check_eq("t4_resync", o_resync, 1'b1);
    ack_pulse();
    check_eq("t4_ack_resync", o_resync, 1'b0);

    // Ack landing in the commit cycle, then a sparse-strobe frame
    set_mags(900, 10); mags[5] = 300;
    send_frame(N, 0, 1'b1);
    ack_commit_g = 1'b1;
    send_frame(N, 0, 1'b1);
    ack_commit_g = 1'b0;
    check_eq("t5_ack_commit_valid", o_valid, 1'b1);
    check_eq("t5_ack_commit_overrun", o_overrun, 1'b0);
    ack_pulse();
    send_frame(N, 3, 1'b1);
    ack_pulse();

    // Reset mid-frame, unsynced data ignored, then a clean frame
    set_mags(0, 20); mags[4] = 800;
    send_frame(N, 0, 1'b1);
    send_frame(4, 0, 1'b1);
    cycle(1'b0, 1'b0, 0, 1'b0, 1'b1);
    idle(1);
    check_eq("t6_rst_valid", o_valid, 1'b0);
    check_eq("t6_rst_bin", o_peak_bin, 0);
    check_eq("t6_rst_mag", o_peak_mag, 0);
    check_eq("t6_rst_detect", o_detect, 1'b0);
    send_frame(N, 0, 1'b0);
    idle(3);
    check_eq("t6_nosync_valid", o_valid, 1'b0);
    set_mags(900, 10); mags[5] = 300;
    send_frame(N, 0, 1'b1);

    idle(3);
    check_eq("sb_drain", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
